// File: rtl/lvds_rx_aligner.sv
// Serial-to-parallel word aligner: hunts a sync word, qualifies lock over LOCK_COUNT words, then emits words.
// DOUT/DVALID update on the edge sampling a word's last bit (0-cycle latency); no backpressure, CE gates all state.
module lvds_rx_aligner #(
   parameter int               WIDTH      = 10,
   parameter logic [WIDTH-1:0] SYNC_WORD  = 10'b1111100000,
   parameter int               LOCK_COUNT = 4
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             CE,
   input  logic             DIN,
   input  logic             RESYNC,
   output logic [WIDTH-1:0] DOUT,
   output logic             DVALID,
   output logic             LOCKED,
   output logic             ALIGN_ERR
);

   localparam int             BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0]  LAST_BIT = BW'(WIDTH - 1);
   localparam logic [3:0]     LOCK_TGT = 4'(LOCK_COUNT);

   typedef enum logic [1:0] {
      HUNT,
      VERIFY,
      LOCK
   } state_t;

   state_t           state;
   // Only WIDTH-1 bits of history are kept; the incoming bit completes the word.
   logic [WIDTH-2:0] sreg;
   logic [BW-1:0]    bitcnt;
   logic [3:0]       match_cnt;
   logic [WIDTH-1:0] next_sreg;
   logic             is_sync;
   logic             boundary;

   assign next_sreg = {sreg, DIN};
   assign is_sync   = (next_sreg == SYNC_WORD);
   assign boundary  = (bitcnt == LAST_BIT);

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         sreg      <= '0;
         bitcnt    <= '0;
         match_cnt <= '0;
         state     <= HUNT;
         DOUT      <= '0;
         DVALID    <= 1'b0;
         LOCKED    <= 1'b0;
         ALIGN_ERR <= 1'b0;
      end else if (!CE) begin
         DVALID    <= 1'b0;
         ALIGN_ERR <= 1'b0;
      end else begin
         sreg      <= next_sreg[WIDTH-2:0];
         DVALID    <= 1'b0;
         ALIGN_ERR <= 1'b0;
         if (RESYNC) begin
            state     <= HUNT;
            LOCKED    <= 1'b0;
            match_cnt <= '0;
            bitcnt    <= '0;
         end else begin
            case (state)
               HUNT: begin
                  if (is_sync) begin
                     bitcnt    <= '0;
                     match_cnt <= 4'd1;
                     if (LOCK_COUNT == 1) begin
                        state  <= LOCK;
                        LOCKED <= 1'b1;
                     end else begin
                        state  <= VERIFY;
                     end
                  end
               end
               VERIFY: begin
                  if (boundary) begin
                     bitcnt <= '0;
                     if (is_sync) begin
                        match_cnt <= match_cnt + 4'd1;
                        if (match_cnt + 4'd1 == LOCK_TGT) begin
                           state  <= LOCK;
                           LOCKED <= 1'b1;
                        end
                     end else begin
                        state     <= HUNT;
                        match_cnt <= '0;
                        ALIGN_ERR <= 1'b1;
                     end
                  end else begin
                     bitcnt <= bitcnt + BW'(1);
                  end
               end
               LOCK: begin
                  // Sync words are plain data here; lock is only dropped by RESYNC or reset.
                  if (boundary) begin
                     bitcnt <= '0;
                     DOUT   <= next_sreg;
                     DVALID <= 1'b1;
                  end else begin
                     bitcnt <= bitcnt + BW'(1);
                  end
               end
               default: begin
                  state <= HUNT;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lvds_rx_aligner.sv
// Directed bench: expected output events are queued at stimulus time and matched by a negedge monitor.
module tb_lvds_rx_aligner;

   localparam int EV_DV   = 0;
   localparam int EV_ERR  = 1;
   localparam int EV_RISE = 2;
   localparam int EV_FALL = 3;
   localparam int EV_NONE = -1;

   typedef struct {
      int         kind;
      int         cyc;
      logic [9:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic       ce;
   logic       din;
   logic       resync;
   logic [9:0] dout;
   logic       dvalid;
   logic       locked;
   logic       align_err;

   int  cyc = 0;
   int  n_cmp = 0;
   int  n_err = 0;
   bit  mon_en = 1'b0;
   logic prev_locked = 1'b0;
   ev_t exp_q[$];

   lvds_rx_aligner #(
      .WIDTH(10),
      .SYNC_WORD(10'b1111100000),
      .LOCK_COUNT(4)
   ) dut (
      .CLK(clk),
      .RSTN(rstn),
      .CE(ce),
      .DIN(din),
      .RESYNC(resync),
      .DOUT(dout),
      .DVALID(dvalid),
      .LOCKED(locked),
      .ALIGN_ERR(align_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input int kind, input logic [9:0] data);
      ev_t e;
      e.kind = kind;
      e.cyc  = cyc + 1;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Shifts a word MSB first; the expected event (if any) belongs to the last bit's edge.
   task automatic send_word(input logic [9:0] w, input int kind);
      for (int i = 9; i >= 0; i--) begin
         if (i == 0 && kind != EV_NONE) push_ev(kind, w);
         din = w[i];
         tick();
      end
   endtask

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic match_ev(input int kind);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL event: got unexpected kind %0d at cycle %0d, expected none", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc || (kind == EV_DV && e.data !== dout)) begin
            n_err++;
            $display("FAIL event: got kind %0d cycle %0d dout 0x%0h, expected kind %0d cycle %0d dout 0x%0h",
                     kind, cyc, dout, e.kind, e.cyc, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (align_err === 1'b1) match_ev(EV_ERR);
         if (dvalid === 1'b1) match_ev(EV_DV);
         if (locked !== prev_locked) match_ev(locked ? EV_RISE : EV_FALL);
         prev_locked = locked;
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL event: got nothing, expected kind %0d at cycle %0d", exp_q[0].kind, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      rstn   = 1'b0;
      ce     = 1'b0;
      din    = 1'b0;
      resync = 1'b0;

      // Reset with CE low must still clear everything.
      tick();
      tick();
      check("rst_dout", dout, 10'h000);
      check("rst_dvalid", {9'd0, dvalid}, 10'h000);
      check("rst_locked", {9'd0, locked}, 10'h000);
      check("rst_align_err", {9'd0, align_err}, 10'h000);
      prev_locked = locked;
      mon_en = 1'b1;

      rstn = 1'b1;
      ce   = 1'b1;
      repeat (50) tick();
      check("idle_locked", {9'd0, locked}, 10'h000);

      // Acquisition: junk, four syncs, then first data word.
      din = 1'b1; tick();
      din = 1'b0; tick();
      din = 1'b1; tick();
      send_word(10'h3E0, EV_NONE);
      send_word(10'h3E0, EV_NONE);
      send_word(10'h3E0, EV_NONE);
      send_word(10'h3E0, EV_RISE);
      send_word(10'h2A5, EV_DV);

      // Back-to-back stream, including a sync pattern passed as data.
      send_word(10'h001, EV_DV);
      send_word(10'h3FF, EV_DV);
      send_word(10'h3E0, EV_DV);

      // CE gap of 5 cycles after 4 bits of 0x1C3.
      for (int i = 9; i >= 6; i--) begin
         din = 10'h1C3 >> i;
         tick();
      end
      ce = 1'b0;
      for (int i = 0; i < 5; i++) begin
         din = i[0];
         tick();
      end
      ce = 1'b1;
      for (int i = 5; i >= 0; i--) begin
         if (i == 0) push_ev(EV_DV, 10'h1C3);
         din = 10'h1C3 >> i;
         tick();
      end

      // RESYNC on the boundary edge of 0x0F0.
      for (int i = 9; i >= 1; i--) begin
         din = 10'h0F0 >> i;
         tick();
      end
      push_ev(EV_FALL, 10'h000);
      resync = 1'b1;
      din    = 1'b0;
      tick();
      resync = 1'b0;
      check("resync_dout", dout, 10'h1C3);
      check("resync_dvalid", {9'd0, dvalid}, 10'h000);
      check("resync_locked", {9'd0, locked}, 10'h000);

      // Failed qualification, then a clean re-lock.
      send_word(10'h3E0, EV_NONE);
      send_word(10'h3E0, EV_NONE);
      send_word(10'h155, EV_ERR);
      send_word(10'h3E0, EV_NONE);
      send_word(10'h3E0, EV_NONE);
      send_word(10'h3E0, EV_NONE);
      send_word(10'h3E0, EV_RISE);
      send_word(10'h2A5, EV_DV);

      // Reset while locked, with CE low on the same edge.
      push_ev(EV_FALL, 10'h000);
      rstn = 1'b0;
      ce   = 1'b0;
      tick();
      check("lrst_dout", dout, 10'h000);
      check("lrst_dvalid", {9'd0, dvalid}, 10'h000);
      check("lrst_locked", {9'd0, locked}, 10'h000);
      check("lrst_align_err", {9'd0, align_err}, 10'h000);
      rstn = 1'b1;
      ce   = 1'b1;
      din  = 1'b0;
      repeat (5) tick();

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain: got %0d pending events, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
